// File: rtl/ff_emu_spi_ctrl_if.sv
// Pin-side bundle of ff_emu_spi_ctrl: FMU SPI slave inputs, read return path,
// fiber control outputs and the flattened register view.
interface ff_emu_spi_ctrl_if #(
  parameter int unsigned NCS    = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8
);
  logic [NCS-1:0]             fmu_spi_cs;
  logic                       fmu_spi_clk;
  logic                       fmu_spi_dat;
  logic                       ctrl_sigdet;
  logic                       fmu_spi_busy;
  logic                       fmu_spi_rtn_clk;
  logic                       fmu_spi_rtn_dat;
  logic                       ctrl_tdis;
  logic                       ctrl_fiber_det;
  logic                       rst_ffemu;
  logic                       spi_err;
  logic [NCS*NREG*DATA_W-1:0] regs;

  modport master (
    output fmu_spi_cs, fmu_spi_clk, fmu_spi_dat, ctrl_sigdet,
    input  fmu_spi_busy, fmu_spi_rtn_clk, fmu_spi_rtn_dat, ctrl_tdis, ctrl_fiber_det,
    input  rst_ffemu, spi_err, regs
  );

  modport slave (
    input  fmu_spi_cs, fmu_spi_clk, fmu_spi_dat, ctrl_sigdet,
    output fmu_spi_busy, fmu_spi_rtn_clk, fmu_spi_rtn_dat, ctrl_tdis, ctrl_fiber_det,
    output rst_ffemu, spi_err, regs
  );
endinterface

// File: rtl/ff_emu_spi_ctrl.sv
// FMU SPI slave with NCS banks of NREG registers, return-path readback and debounced fiber
// detect. Define FFEMU_RDBK_EN to enable the read return path; otherwise legacy tie-offs.
module ff_emu_spi_ctrl #(
  parameter int unsigned NCS     = 2,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NREG    = 8,
  parameter int unsigned DEB_CYC = 1024,
  parameter int unsigned RTN_DIV = 4
) (
  input logic              clk,
  input logic              rst,
  ff_emu_spi_ctrl_if.slave bus
);
  localparam int unsigned NREGS = NCS * NREG;
  localparam int unsigned IdxW  = $clog2(NREGS);
  localparam int unsigned BankW = (NCS > 1) ? $clog2(NCS) : 1;
  localparam int unsigned CntW  = $clog2(DATA_W) + 1;
  localparam int unsigned DebW  = $clog2(DEB_CYC) + 1;

  typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdTx, StDrain} state_e;

  // Synchronizers; the third stage aligns CS with the registered SPI edge pulse.
  logic [NCS-1:0] cs_s1, cs_s2, cs_s3;
  logic           sclk_s1, sclk_s2, sclk_s3;
  logic           sdat_s1, sdat_s2;
  logic           sig_s1, sig_s2, sig_s3;
  logic           rise_q, bit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1   <= '1;
      cs_s2   <= '1;
      cs_s3   <= '1;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      sdat_s1 <= 1'b0;
      sdat_s2 <= 1'b0;
      sig_s1  <= 1'b0;
      sig_s2  <= 1'b0;
      sig_s3  <= 1'b0;
      rise_q  <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      cs_s1   <= bus.fmu_spi_cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      sclk_s1 <= bus.fmu_spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      sdat_s1 <= bus.fmu_spi_dat;
      sdat_s2 <= sdat_s1;
      sig_s1  <= bus.ctrl_sigdet;
      sig_s2  <= sig_s1;
      sig_s3  <= sig_s2;
      rise_q  <= sclk_s2 & ~sclk_s3;
      bit_q   <= sdat_s2;
    end
  end

  logic [NCS-1:0]   cs_low;
  logic             one_low, multi_low, all_high;
  logic [BankW-1:0] bank_enc;

  always_comb begin
    cs_low    = ~cs_s3;
    one_low   = $onehot(cs_low);
    multi_low = (cs_low != '0) && !one_low;
    all_high  = &cs_s3;
    bank_enc  = '0;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (cs_low[i]) bank_enc = BankW'(i);
    end
  end

  state_e            state_q, state_d;
  logic [BankW-1:0]  bank_q, bank_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [7:0]        cmd_nx;
  logic [DATA_W-2:0] wsh_q, wsh_d;
  logic [DATA_W-1:0] wsh_nx;
  logic              err_q, err_d;
  logic              we;
  logic [IdxW-1:0]   wr_idx;
  logic              wr_in_range;
  logic [DATA_W-1:0] regs_q [NREGS];
`ifdef FFEMU_RDBK_EN
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic [$clog2(RTN_DIV)-1:0] div_q, div_d;
  logic                   rclk_q, rclk_d;
  logic                   busy_q, busy_d;
  logic [IdxW-1:0]        rd_idx;
  logic                   rd_in_range;
`endif

  always_comb begin
    cmd_nx      = {cmd_q, bit_q};
    wsh_nx      = {wsh_q, bit_q};
    wr_in_range = 32'(cmd_q) < NREG;
    wr_idx      = IdxW'(32'(bank_q) * NREG + 32'(cmd_q));
`ifdef FFEMU_RDBK_EN
    rd_in_range = 32'(cmd_nx[6:0]) < NREG;
    rd_idx      = IdxW'(32'(bank_q) * NREG + 32'(cmd_nx[6:0]));
`endif
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    wsh_d   = wsh_q;
    err_d   = err_q;
    we      = 1'b0;
`ifdef FFEMU_RDBK_EN
    tx_d    = tx_q;
    div_d   = div_q;
    rclk_d  = rclk_q;
    busy_d  = busy_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (multi_low) begin
          err_d = 1'b1;
        end else if (one_low) begin
          state_d = StCmd;
          bank_d  = bank_enc;
          cnt_d   = '0;
        end
      end
      StCmd: begin
        if (all_high) begin
          state_d = StIdle;
        end else if (rise_q) begin
          cmd_d = cmd_nx[6:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(7)) begin
            cnt_d = '0;
            if (cmd_nx[7]) begin
`ifdef FFEMU_RDBK_EN
              state_d = StRdTx;
              busy_d  = 1'b1;
              rclk_d  = 1'b0;
              div_d   = '0;
              tx_d    = rd_in_range ? regs_q[rd_idx] : '0;
              if (!rd_in_range) err_d = 1'b1;
`else
              state_d = StDrain;
`endif
            end else begin
              state_d = StWdata;
            end
          end
        end
      end
      StWdata: begin
        // Abort wins over a commit landing in the same cycle.
        if (all_high) begin
          state_d = StIdle;
        end else if (rise_q) begin
          wsh_d = wsh_nx[DATA_W-2:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            if (wr_in_range) we = 1'b1;
            else             err_d = 1'b1;
            state_d = StDrain;
          end
        end
      end
`ifdef FFEMU_RDBK_EN
      StRdTx: begin
        if (32'(div_q) == RTN_DIV - 1) begin
          div_d = '0;
          if (!rclk_q) begin
            rclk_d = 1'b1;
          end else if (cnt_q == CntW'(DATA_W - 1)) begin
            rclk_d  = 1'b0;
            busy_d  = 1'b0;
            tx_d    = '0;
            state_d = StDrain;
          end else begin
            rclk_d = 1'b0;
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            cnt_d  = cnt_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      StDrain: begin
        if (all_high) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bank_q  <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      wsh_q   <= '0;
      err_q   <= 1'b0;
`ifdef FFEMU_RDBK_EN
      tx_q    <= '0;
      div_q   <= '0;
      rclk_q  <= 1'b0;
      busy_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      wsh_q   <= wsh_d;
      err_q   <= err_d;
`ifdef FFEMU_RDBK_EN
      tx_q    <= tx_d;
      div_q   <= div_d;
      rclk_q  <= rclk_d;
      busy_q  <= busy_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wr_idx] <= wsh_nx;
    end
  end

  // Debounce: counter restarts on any synchronized change, saturates at DEB_CYC-1.
  logic [DebW-1:0] deb_q, deb_d;
  logic            det_q, det_d;
  logic            sig_diff;

  always_comb begin
    sig_diff = sig_s2 ^ sig_s3;
    det_d    = det_q;
    if (sig_diff)                           deb_d = '0;
    else if (deb_q != DebW'(DEB_CYC - 1))   deb_d = deb_q + 1'b1;
    else                                    deb_d = deb_q;
    if (!sig_diff && deb_d == DebW'(DEB_CYC - 1)) det_d = sig_s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      det_q <= 1'b0;
    end else begin
      deb_q <= deb_d;
      det_q <= det_d;
    end
  end

  logic [NREGS*DATA_W-1:0] regs_flat;
  for (genvar g = 0; g < NREGS; g++) begin : g_regs
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  logic [DATA_W-1:0] ctrl0;
  assign ctrl0              = regs_q[0];
  assign bus.regs           = regs_flat;
  assign bus.ctrl_fiber_det = det_q;
  assign bus.ctrl_tdis      = ctrl0[1] ? ctrl0[0] : ~det_q;
  assign bus.rst_ffemu      = ctrl0[2];
  assign bus.spi_err        = err_q;
`ifdef FFEMU_RDBK_EN
  assign bus.fmu_spi_busy    = busy_q;
  assign bus.fmu_spi_rtn_clk = rclk_q;
  assign bus.fmu_spi_rtn_dat = busy_q & tx_q[DATA_W-1];
`else
  assign bus.fmu_spi_busy    = 1'b1;
  assign bus.fmu_spi_rtn_clk = 1'b0;
  assign bus.fmu_spi_rtn_dat = 1'b0;
`endif
endmodule

// File: tb/tb_ff_emu_spi_ctrl.sv
// Self-checking bench for ff_emu_spi_ctrl: random SPI frames against a register-bank model,
// debounce timing, error cases, abort and reset during readback.
module tb_ff_emu_spi_ctrl;
  localparam int unsigned NCS     = 2;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NREG    = 8;
  localparam int unsigned DEB_CYC = 1024;
  localparam int unsigned RTN_DIV = 4;
  localparam int unsigned FLAT_W  = NCS * NREG * DATA_W;
`ifdef FFEMU_RDBK_EN
  localparam logic IDLE_BUSY = 1'b0;
`else
  localparam logic IDLE_BUSY = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ff_emu_spi_ctrl_if #(.NCS(NCS), .DATA_W(DATA_W), .NREG(NREG)) bus ();

  ff_emu_spi_ctrl #(
    .NCS(NCS), .DATA_W(DATA_W), .NREG(NREG), .DEB_CYC(DEB_CYC), .RTN_DIV(RTN_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: register banks plus the sticky error flag.
  logic [DATA_W-1:0] mdl [NCS][NREG];
  logic              err_m;

  function automatic logic [FLAT_W-1:0] flat_model();
    logic [FLAT_W-1:0] f;
    for (int b = 0; b < NCS; b++)
      for (int r = 0; r < NREG; r++) f[(b*NREG+r)*DATA_W +: DATA_W] = mdl[b][r];
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < NCS; b++)
      for (int r = 0; r < NREG; r++) mdl[b][r] = '0;
    err_m = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fmu_spi_cs  = '1;
    bus.fmu_spi_clk = 1'b0;
    bus.fmu_spi_dat = 1'b0;
    bus.ctrl_sigdet = 1'b0;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(3);
  endtask

  task automatic spi_bit(input logic b);
    bus.fmu_spi_dat = b;
    tick(4);
    bus.fmu_spi_clk = 1'b1;
    tick(4);
    bus.fmu_spi_clk = 1'b0;
  endtask

  task automatic select(input int idx);
    logic [NCS-1:0] m;
    m = '1;
    m[idx] = 1'b0;
    bus.fmu_spi_cs = m;
    tick(6);
  endtask

  task automatic release_cs();
    bus.fmu_spi_cs = '1;
    tick(8);
  endtask

  task automatic do_write(input int bank, input logic [6:0] addr, input logic [DATA_W-1:0] data);
    select(bank);
    spi_bit(1'b0);
    for (int i = 6; i >= 0; i--) spi_bit(addr[i]);
    for (int i = DATA_W - 1; i >= 1; i--) spi_bit(data[i]);
    bus.fmu_spi_dat = data[0];
    tick(4);
    bus.fmu_spi_clk = 1'b1;
    tick(3);
    total++;
    if (bus.regs !== flat_model()) begin
      bad++;
      $display("FAIL write_early: regs=%h want %h", bus.regs, flat_model());
    end
    tick(1);
    if (int'(addr) < NREG) mdl[bank][addr] = data;
    else                   err_m = 1'b1;
    total++;
    if (bus.regs !== flat_model()) begin
      bad++;
      $display("FAIL write_commit: regs=%h want %h", bus.regs, flat_model());
    end
    total++;
    if (bus.spi_err !== err_m) begin
      bad++;
      $display("FAIL write_err: spi_err=%b want %b", bus.spi_err, err_m);
    end
    tick(3);
    bus.fmu_spi_clk = 1'b0;
    release_cs();
  endtask

  task automatic do_read(input int bank, input logic [6:0] addr);
`ifdef FFEMU_RDBK_EN
    logic [DATA_W-1:0] exp_v, cap;
    int busy_cnt, nrise;
    logic prev;
    exp_v = (int'(addr) < NREG) ? mdl[bank][addr] : '0;
    if (int'(addr) >= NREG) err_m = 1'b1;
    select(bank);
    spi_bit(1'b1);
    for (int i = 6; i >= 1; i--) spi_bit(addr[i]);
    bus.fmu_spi_dat = addr[0];
    tick(4);
    bus.fmu_spi_clk = 1'b1;
    tick(3);
    total++;
    if (bus.fmu_spi_busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_busy_early: busy=%b want 0", bus.fmu_spi_busy);
    end
    tick(1);
    bus.fmu_spi_clk = 1'b0;
    total++;
    if ({bus.fmu_spi_busy, bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat} !== {2'b10, exp_v[DATA_W-1]})
    begin
      bad++;
      $display("FAIL rd_start: busy/rclk/rdat=%b%b%b want 10%b", bus.fmu_spi_busy,
               bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat, exp_v[DATA_W-1]);
    end
    busy_cnt = 1;
    nrise = 0;
    cap = '0;
    prev = bus.fmu_spi_rtn_clk;
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      if (bus.fmu_spi_rtn_clk && !prev) begin
        cap = {cap[DATA_W-2:0], bus.fmu_spi_rtn_dat};
        nrise++;
      end
      prev = bus.fmu_spi_rtn_clk;
      if (!bus.fmu_spi_busy) break;
      busy_cnt++;
    end
    total++;
    if (busy_cnt != int'(2 * RTN_DIV * DATA_W)) begin
      bad++;
      $display("FAIL rd_busy_len: cycles=%0d want %0d", busy_cnt, 2 * RTN_DIV * DATA_W);
    end
    total++;
    if (cap !== exp_v || nrise != int'(DATA_W)) begin
      bad++;
      $display("FAIL rd_data: got %h (%0d rises) want %h (%0d rises)", cap, nrise, exp_v, DATA_W);
    end
    total++;
    if ({bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat, bus.spi_err} !== {2'b00, err_m}) begin
      bad++;
      $display("FAIL rd_end: rclk/rdat/err=%b%b%b want 00%b", bus.fmu_spi_rtn_clk,
               bus.fmu_spi_rtn_dat, bus.spi_err, err_m);
    end
`else
    select(bank);
    spi_bit(1'b1);
    for (int i = 6; i >= 0; i--) spi_bit(addr[i]);
    tick(10);
    total++;
    if ({bus.fmu_spi_busy, bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat} !== 3'b100 ||
        bus.regs !== flat_model()) begin
      bad++;
      $display("FAIL rd_tieoff: busy/rclk/rdat=%b%b%b want 100, regs=%h want %h",
               bus.fmu_spi_busy, bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat, bus.regs, flat_model());
    end
`endif
    release_cs();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.ctrl_tdis !== 1'b1 || bus.ctrl_fiber_det !== 1'b0) begin
      bad++;
      $display("FAIL reset_tdis: tdis=%b det=%b want 1 0", bus.ctrl_tdis, bus.ctrl_fiber_det);
    end
    total++;
    if ({bus.fmu_spi_busy, bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat} !== {IDLE_BUSY, 2'b00}) begin
      bad++;
      $display("FAIL reset_rtn: busy/rclk/rdat=%b%b%b want %b00", bus.fmu_spi_busy,
               bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat, IDLE_BUSY);
    end
    total++;
    if (bus.regs !== '0 || bus.spi_err !== 1'b0 || bus.rst_ffemu !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: regs=%h err=%b rst_ffemu=%b want 0", bus.regs, bus.spi_err,
               bus.rst_ffemu);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    do_write(0, 7'h03, 16'hA5C3);
    do_read(0, 7'h03);
    for (int i = 0; i < 6; i++) begin
      do_write(int'($urandom_range(0, NCS - 1)), 7'($urandom_range(1, NREG - 1)),
               DATA_W'($urandom));
    end
    for (int i = 0; i < 4; i++) begin
      do_read(int'($urandom_range(0, NCS - 1)), 7'($urandom_range(0, NREG - 1)));
    end
    total++;
    if (bus.spi_err !== 1'b0) begin
      bad++;
      $display("FAIL rw_err: spi_err=%b want 0", bus.spi_err);
    end
  endtask

  task automatic test_debounce();
    int viol;
    do_reset();
    bus.ctrl_sigdet = 1'b1;
    tick(DEB_CYC + 1);
    total++;
    if (bus.ctrl_fiber_det !== 1'b0 || bus.ctrl_tdis !== 1'b1) begin
      bad++;
      $display("FAIL deb_early: det=%b tdis=%b want 0 1", bus.ctrl_fiber_det, bus.ctrl_tdis);
    end
    tick(1);
    total++;
    if (bus.ctrl_fiber_det !== 1'b1 || bus.ctrl_tdis !== 1'b0) begin
      bad++;
      $display("FAIL deb_rise: det=%b tdis=%b want 1 0", bus.ctrl_fiber_det, bus.ctrl_tdis);
    end
    bus.ctrl_sigdet = 1'b0;
    tick(100);
    bus.ctrl_sigdet = 1'b1;
    viol = 0;
    for (int c = 0; c < 1500; c++) begin
      tick(1);
      if (bus.ctrl_fiber_det !== 1'b1) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL deb_glitch: %0d cycles with det!=1, want 0", viol);
    end
    do_write(0, 7'h00, 16'h0003);
    total++;
    if (bus.ctrl_tdis !== 1'b1) begin
      bad++;
      $display("FAIL tdis_override: tdis=%b want 1", bus.ctrl_tdis);
    end
    do_write(0, 7'h00, 16'h0004);
    total++;
    if (bus.ctrl_tdis !== 1'b0 || bus.rst_ffemu !== 1'b1) begin
      bad++;
      $display("FAIL rst_ffemu: tdis=%b rst_ffemu=%b want 0 1", bus.ctrl_tdis, bus.rst_ffemu);
    end
    bus.ctrl_sigdet = 1'b0;
    tick(DEB_CYC + 2);
    total++;
    if (bus.ctrl_fiber_det !== 1'b0 || bus.ctrl_tdis !== 1'b1) begin
      bad++;
      $display("FAIL deb_fall: det=%b tdis=%b want 0 1", bus.ctrl_fiber_det, bus.ctrl_tdis);
    end
  endtask

  task automatic test_errors();
    do_reset();
    do_write(1, 7'h05, DATA_W'($urandom));
    bus.fmu_spi_cs = '0;
    tick(6);
    for (int i = 0; i < 8 + int'(DATA_W); i++) spi_bit(1'($urandom));
    release_cs();
    err_m = 1'b1;
    total++;
    if (bus.regs !== flat_model() || bus.spi_err !== 1'b1) begin
      bad++;
      $display("FAIL multi_cs: regs=%h err=%b want %h 1", bus.regs, bus.spi_err, flat_model());
    end
    do_reset();
    do_write(0, 7'h7F, DATA_W'($urandom));
    do_reset();
    do_write(1, 7'h02, 16'h1234);
    do_read(1, 7'h40);
  endtask

  task automatic test_abort();
    do_reset();
    select(0);
    spi_bit(1'b0);
    for (int i = 6; i >= 0; i--) spi_bit(1'(7'h02 >> i));
    for (int i = 0; i < 4; i++) spi_bit(1'b1);
    release_cs();
    tick(10);
    total++;
    if (bus.regs !== flat_model() || bus.spi_err !== 1'b0) begin
      bad++;
      $display("FAIL abort: regs=%h err=%b want %h 0", bus.regs, bus.spi_err, flat_model());
    end
    do_write(0, 7'h02, DATA_W'($urandom));
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    do_write(0, 7'h01, 16'hFFFF);
    select(0);
    spi_bit(1'b1);
    for (int i = 6; i >= 0; i--) spi_bit(1'(7'h01 >> i));
    tick(20);
    rst = 1'b1;
    bus.fmu_spi_cs = '1;
    #1;
    total++;
    if ({bus.fmu_spi_busy, bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat} !== {IDLE_BUSY, 2'b00} ||
        bus.regs !== '0) begin
      bad++;
      $display("FAIL rst_mid_read: busy/rclk/rdat=%b%b%b want %b00, regs=%h want 0",
               bus.fmu_spi_busy, bus.fmu_spi_rtn_clk, bus.fmu_spi_rtn_dat, IDLE_BUSY, bus.regs);
    end
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(3);
    do_write(1, 7'h04, DATA_W'($urandom));
    do_read(1, 7'h04);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_debounce();
    test_errors();
    test_abort();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ff_emu_spi_ctrl.md
# ff_emu_spi_ctrl

Parametrised successor to the static fiber/FMU tie-off interface. It implements a real FMU SPI slave with NCS chip selects, each selecting its own bank of NREG registers. Reads return data on the FMU_SPI_RTN_CLK/DAT return path, gated by FMU_SPI_BUSY. CTRL_SIGDET is debounced into CTRL_FIBER_DET, which drives CTRL_TDIS, with a register override. The block sits between the FMU pins (after IBUF/OBUF) and DCFEB core logic, in the CLK domain.

## Interface
- NCS, 2: number of active-low chip selects (1..4).
- DATA_W, 16: register/data word width (8..32).
- NREG, 8: registers per bank (2..128); address values ≥ NREG are out of range.
- DEB_CYC, 1024: CLK cycles CTRL_SIGDET must be stable before CTRL_FIBER_DET follows it.
- RTN_DIV, 4: return-clock half period, in CLK cycles (≥2).

Ports:
- CLK  in  1  system clock (40 MHz)
- RST  in  1  reset; asynchronous and active-high
- FMU_SPI_CS  in  NCS  chip selects, active low, asynchronous
- FMU_SPI_CLK  in  1  SPI clock, asynchronous, ≤ CLK/8
- FMU_SPI_DAT  in  1  SPI data, sampled on FMU_SPI_CLK rising edge
- CTRL_SIGDET  in  1  raw fiber signal detect, asynchronous
- FMU_SPI_BUSY  out  1  high while read data is returned
- FMU_SPI_RTN_CLK  out  1  return clock
- FMU_SPI_RTN_DAT  out  1  return data, MSB first
- CTRL_TDIS  out  1  transmitter disable
- CTRL_FIBER_DET  out  1  debounced signal detect
- RST_FFEMU  out  1  bank-0 register 0 bit 2
- SPI_ERR  out  1  sticky error flag; cleared only by RST
- REGS  out  NCS*NREG*DATA_W  all registers, flattened; bank b, register r at offset (b*NREG+r)*DATA_W

## Operation
- All asynchronous inputs pass through a 2-FF synchronizer. SPI clock edges are detected from the synchronized value.
- Frame selection: exactly one synchronized CS low while the FSM is IDLE starts a frame, and the bank index is latched.
- More than one CS low starts no frame and sets SPI_ERR.
- Frame format, MSB first on rising SPI clock edges:
  - bit 0: R/W (1 = read)
  - bits 1–7: address
  - write only: DATA_W data bits follow.
- FSM states: IDLE → CMD (8 bits) → WDATA (write) or RD_TX (read) → DRAIN → IDLE.
- WDATA: the write commits on the DATA_W-th data bit, one cycle after the edge is detected. An out-of-range address discards the write and sets SPI_ERR. The FSM then enters DRAIN.
- DRAIN: further SPI bits are ignored; the FSM returns to IDLE when all CS are high.
- Abort: all CS high during CMD or WDATA returns the FSM to IDLE with no write and no error.
- RD_TX: entered on the 8th command bit.
  - The addressed register is latched into the TX shifter; out-of-range addresses return 0 and set SPI_ERR.
  - BUSY rises, and RTN_CLK toggles every RTN_DIV cycles, starting low.
  - RTN_DAT updates on RTN_CLK falling edges (the first bit is presented with BUSY).
  - After DATA_W rising edges, RTN_CLK returns low, BUSY and RTN_DAT go to 0, and the FSM enters DRAIN.
  - CS deassertion during RD_TX does not abort the return.
- Register semantics: registers are plain R/W storage. Bank 0, register 0 is control:
  - bit 0: TDIS force value
  - bit 1: override enable
  - bit 2: RST_FFEMU
- CTRL_TDIS = override enable ? TDIS force value : ~CTRL_FIBER_DET.
- Debounce: a counter resets whenever the synchronized SIGDET differs from its previous value. CTRL_FIBER_DET loads the synchronized value when the counter reaches DEB_CYC−1.

## Timing
- Reset values:
  - all registers 0; FSM IDLE; SPI_ERR 0
  - BUSY 0, RTN_CLK 0, RTN_DAT 0
  - CTRL_FIBER_DET 0, so CTRL_TDIS = 1 after reset
  - RST_FFEMU 0
- Input-to-edge-detect latency: 3 CLK cycles. A write is visible on REGS 4 cycles after the last SPI rising edge at the pin.
- BUSY rises 4 cycles after the 8th command edge at the pin. A read lasts 2·RTN_DIV·DATA_W cycles from BUSY rise to fall.
- RST mid-frame or mid-read forces the reset values immediately; the frame is lost.
- CTRL_FIBER_DET changes DEB_CYC+2 cycles after a stable SIGDET transition.

## Configuration
- FFEMU_RDBK_EN
  - Defined: read path as described.
  - Undefined: read frames go straight from CMD to DRAIN. FMU_SPI_BUSY is held at 1, and RTN_CLK/RTN_DAT are held at 0 (legacy tie-off behaviour). Writes and debounce are unchanged.

## Test plan
- Reset with CTRL_SIGDET=0 → CTRL_TDIS=1, BUSY=0, REGS all 0.
- CS0 write 0x03 / 0xA5C3 → bank 0 reg 3 = 0xA5C3 four cycles after the last edge, SPI_ERR=0; then CS0 read 0x83 → RTN_DAT shifts 0xA5C3 MSB first across 16 RTN_CLK rises, BUSY high for 128 cycles (RTN_DIV=4).
- CTRL_SIGDET held 1 → CTRL_TDIS falls after DEB_CYC+2 cycles; a glitch shorter than DEB_CYC → no change. Then write bank 0 reg 0 = 0x0003 → CTRL_TDIS=1 despite the fiber being detected.
- CS0 and CS1 low together → no register change, SPI_ERR=1. Write to address 0x7F → REGS unchanged, SPI_ERR=1.
- CS released after 12 of 24 write bits → no write, FSM IDLE; the next full frame succeeds.
- RST asserted during RD_TX → BUSY, RTN_CLK, RTN_DAT = 0 immediately, FSM IDLE.
